// File: rtl/ahb_fir_pkg.sv
// Shared types and default address map for the FIR subsystem AHB-Lite fabric.
package ahb_fir_pkg;

  localparam int FIR_NSLV   = 4;
  localparam int FIR_AWIDTH = 32;
  localparam int FIR_DWIDTH = 32;

  typedef enum logic [1:0] {
    HT_IDLE   = 2'd0,
    HT_BUSY   = 2'd1,
    HT_NONSEQ = 2'd2,
    HT_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [1:0] {
    OKAY = 2'd0,
    ERR1 = 2'd1,
    ERR2 = 2'd2
  } def_state_t;

  // Four 256 MB regions stacked from address zero; index 0 is the rightmost entry.
  localparam logic [FIR_NSLV-1:0][FIR_AWIDTH-1:0] FIR_SLV_BASE = {
    32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
  };
  localparam logic [FIR_NSLV-1:0][FIR_AWIDTH-1:0] FIR_SLV_MASK = {
    32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000
  };

  // NONSEQ and SEQ are the only transfer types that demand a response.
  function automatic logic trans_active(input logic [1:0] t);
    return t[1];
  endfunction

endpackage

// File: rtl/ahb_default_slv.sv
// Default slave: answers unmapped NONSEQ/SEQ with the two-cycle AHB ERROR
// response and unmapped IDLE/BUSY with a zero-wait OKAY.
module ahb_default_slv
  import ahb_fir_pkg::*;
(
  input  logic       hclk,
  input  logic       hresetn,
  input  logic       hready,
  input  logic [1:0] htrans,
  input  logic       unmapped,
  output logic       hreadyout,
  output logic       hresp,
  output def_state_t state
);

  def_state_t r_state;
  logic       r_hreadyout;
  logic       r_hresp;
  logic       w_accept;

  // An unmapped transfer needing a response is accepted only when the bus completes.
  assign w_accept = hready & trans_active(htrans) & unmapped;

  // State and its registered response outputs advance together.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_state     <= OKAY;
      r_hreadyout <= 1'b1;
      r_hresp     <= 1'b0;
    end else begin
      case (r_state)
        OKAY: begin
          if (w_accept) begin
            r_state     <= ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end
        end
        ERR1: begin
          r_state     <= ERR2;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b1;
        end
        ERR2: begin
          if (w_accept) begin
            r_state     <= ERR1;
            r_hreadyout <= 1'b0;
            r_hresp     <= 1'b1;
          end else begin
            r_state     <= OKAY;
            r_hreadyout <= 1'b1;
            r_hresp     <= 1'b0;
          end
        end
        default: begin
          r_state     <= OKAY;
          r_hreadyout <= 1'b1;
          r_hresp     <= 1'b0;
        end
      endcase
    end
  end

  assign hreadyout = r_hreadyout;
  assign hresp     = r_hresp;
  assign state     = r_state;

endmodule

// File: rtl/ahb_slv_router.sv
// AHB-Lite slave-side router: programmable region decode, registered
// data-phase select, and response/read-data mux back to the master.
// Handshake: a transfer's address phase is accepted on a rising hclk edge
// with hready=1; its data phase ends on the next rising edge with hready=1,
// and every slave sees the same hready so all phases stay in lockstep.
module ahb_slv_router
  import ahb_fir_pkg::*;
#(
  parameter int NSLV   = FIR_NSLV,
  parameter int AWIDTH = FIR_AWIDTH,
  parameter int DWIDTH = FIR_DWIDTH,
  parameter logic [NSLV-1:0][AWIDTH-1:0] SLV_BASE = FIR_SLV_BASE,
  parameter logic [NSLV-1:0][AWIDTH-1:0] SLV_MASK = FIR_SLV_MASK
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [AWIDTH-1:0]      haddr,
  input  logic [1:0]             htrans,
  output logic [NSLV-1:0]        hsel,
  input  logic [NSLV*DWIDTH-1:0] hrdata_s,
  input  logic [NSLV-1:0]        hreadyout_s,
  input  logic [NSLV-1:0]        hresp_s,
  output logic [DWIDTH-1:0]      hrdata,
  output logic                   hready,
  output logic                   hresp
);

  // One extra code beyond the slaves names the default slave.
  localparam int SW = $clog2(NSLV + 1);
  localparam logic [SW-1:0] DEF_IDX = SW'(NSLV);

  logic              w_hit;
  logic [SW-1:0]     w_idx;
  logic [SW-1:0]     r_dsel;
  logic [DWIDTH-1:0] w_hrdata;
  logic              w_hready;
  logic              w_hresp;
  logic              w_def_ready;
  logic              w_def_resp;
  def_state_t        w_def_state;

  // Region decode; scanning downward lets the lowest matching index win.
  always_comb begin
    w_hit = 1'b0;
    w_idx = DEF_IDX;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((haddr & SLV_MASK[i]) == SLV_BASE[i]) begin
        w_hit = 1'b1;
        w_idx = SW'(i);
      end
    end
  end

  // One-hot address-phase select, forced quiet while reset is held.
  always_comb begin
    hsel = '0;
    for (int i = 0; i < NSLV; i++) begin
      hsel[i] = hresetn & w_hit & (w_idx == SW'(i));
    end
  end

  // Data-phase owner follows the address phase only when the bus completes.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dsel <= DEF_IDX;
    end else if (w_hready) begin
      r_dsel <= w_idx;
    end
  end

  ahb_default_slv u_def (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hready    (w_hready),
    .htrans    (htrans),
    .unmapped  (~w_hit),
    .hreadyout (w_def_ready),
    .hresp     (w_def_resp),
    .state     (w_def_state)
  );

  // Response mux keyed only by the registered select, so it cannot move mid-wait.
  always_comb begin
    w_hrdata = '0;
    w_hready = w_def_ready;
    w_hresp  = w_def_resp;
    for (int i = 0; i < NSLV; i++) begin
      if (r_dsel == SW'(i)) begin
        w_hrdata = hrdata_s[i*DWIDTH +: DWIDTH];
        w_hready = hreadyout_s[i];
        w_hresp  = hresp_s[i];
      end
    end
  end

  assign hrdata = w_hrdata;
  assign hready = w_hready;
  assign hresp  = w_hresp;

  // The first ERROR cycle of the default slave must always stall the bus.
  a_def_err1_stalls: assert property (@(posedge hclk) disable iff (!hresetn)
    ((r_dsel == DEF_IDX) && (w_def_state == ERR1)) |-> !hready);

  // Never more than one slave selected in the address phase.
  a_hsel_onehot0: assert property (@(posedge hclk) $onehot0(hsel));

endmodule

// File: tb/tb_ahb_slv_router.sv
// Directed bench for ahb_slv_router: default map, a three-slave map and an
// overlapping map, all driven from one shared address/transfer bus.
module tb_ahb_slv_router;
  import ahb_fir_pkg::*;

  // ---------------- clock / reset ----------------
  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn;
  logic [31:0] haddr;
  logic [1:0]  htrans;

  // instance a: default four-slave map
  logic [127:0] a_hrdata_s;
  logic [3:0]   a_hreadyout_s, a_hresp_s, a_hsel;
  logic [31:0]  a_hrdata;
  logic         a_hready, a_hresp;

  // instance b: slave 3 removed
  localparam logic [2:0][31:0] B_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
  localparam logic [2:0][31:0] B_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  logic [95:0]  b_hrdata_s;
  logic [2:0]   b_hreadyout_s, b_hresp_s, b_hsel;
  logic [31:0]  b_hrdata;
  logic         b_hready, b_hresp;

  // instance c: slaves 0 and 2 both cover 0x2xxx_xxxx
  localparam logic [3:0][31:0] C_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [3:0][31:0] C_MASK = {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};
  logic [127:0] c_hrdata_s;
  logic [3:0]   c_hreadyout_s, c_hresp_s, c_hsel;
  logic [31:0]  c_hrdata;
  logic         c_hready, c_hresp;

  ahb_slv_router u_dut (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel(a_hsel), .hrdata_s(a_hrdata_s), .hreadyout_s(a_hreadyout_s),
    .hresp_s(a_hresp_s), .hrdata(a_hrdata), .hready(a_hready), .hresp(a_hresp)
  );

  ahb_slv_router #(.NSLV(3), .SLV_BASE(B_BASE), .SLV_MASK(B_MASK)) u_dut3 (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel(b_hsel), .hrdata_s(b_hrdata_s), .hreadyout_s(b_hreadyout_s),
    .hresp_s(b_hresp_s), .hrdata(b_hrdata), .hready(b_hready), .hresp(b_hresp)
  );

  ahb_slv_router #(.NSLV(4), .SLV_BASE(C_BASE), .SLV_MASK(C_MASK)) u_ovl (
    .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .htrans(htrans),
    .hsel(c_hsel), .hrdata_s(c_hrdata_s), .hreadyout_s(c_hreadyout_s),
    .hresp_s(c_hresp_s), .hrdata(c_hrdata), .hready(c_hready), .hresp(c_hresp)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic sample();
    @(negedge hclk);
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans);
    haddr  = addr;
    htrans = trans;
  endtask

  // Hold reset over a mapped address so the hsel gating is visible, then release.
  task automatic do_reset();
    hresetn = 1'b0;
    drive(32'h1000_0000, HT_IDLE);
    sample();
    chk("rst_a_hsel",   64'(a_hsel),   64'h0);
    chk("rst_a_hready", 64'(a_hready), 64'h1);
    chk("rst_a_hresp",  64'(a_hresp),  64'h0);
    chk("rst_a_hrdata", 64'(a_hrdata), 64'h0);
    chk("rst_b_hsel",   64'(b_hsel),   64'h0);
    tick();
    hresetn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    hresetn       = 1'b0;
    haddr         = '0;
    htrans        = HT_IDLE;
    a_hrdata_s    = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
    a_hreadyout_s = 4'hF;
    a_hresp_s     = 4'h0;
    b_hrdata_s    = {32'hBEEF_0002, 32'hBEEF_0001, 32'hBEEF_0000};
    b_hreadyout_s = 3'b111;
    b_hresp_s     = 3'b000;
    c_hrdata_s    = {32'hD00D_0003, 32'hD00D_0002, 32'hD00D_0001, 32'hD00D_0000};
    c_hreadyout_s = 4'hF;
    c_hresp_s     = 4'h0;

    // read from slave 1
    do_reset();
    drive(32'h1000_0040, HT_NONSEQ);
    sample();
    chk("s1_hsel", 64'(a_hsel), 64'h2);
    tick();
    drive(32'h0000_0000, HT_IDLE);
    sample();
    chk("s1_hrdata", 64'(a_hrdata), 64'hCAFE_0001);
    chk("s1_hready", 64'(a_hready), 64'h1);
    chk("s1_hresp",  64'(a_hresp),  64'h0);

    // slave 2 stalls three cycles with a slave-0 transfer queued behind it
    tick();
    drive(32'h2000_0000, HT_NONSEQ);
    sample();
    chk("s2_hsel", 64'(a_hsel), 64'h4);
    tick();
    a_hreadyout_s = 4'b1011;
    drive(32'h0000_0010, HT_NONSEQ);
    for (int k = 0; k < 3; k++) begin
      sample();
      chk("s2_wait_hready", 64'(a_hready), 64'h0);
      chk("s2_wait_dsel",   64'(u_dut.r_dsel), 64'h2);
      chk("s2_wait_hrdata", 64'(a_hrdata), 64'hCAFE_0002);
      chk("s2_wait_hsel",   64'(a_hsel), 64'h1);
      tick();
    end
    a_hreadyout_s = 4'hF;
    sample();
    chk("s2_done_hready", 64'(a_hready), 64'h1);
    chk("s2_done_hrdata", 64'(a_hrdata), 64'hCAFE_0002);
    chk("s2_done_dsel",   64'(u_dut.r_dsel), 64'h2);
    tick();
    drive(32'h0000_0010, HT_IDLE);
    sample();
    chk("s0_dsel",   64'(u_dut.r_dsel), 64'h0);
    chk("s0_hrdata", 64'(a_hrdata), 64'hCAFE_0000);
    chk("s0_hready", 64'(a_hready), 64'h1);

    // slave 3 error response passes straight through
    tick();
    drive(32'h3000_0000, HT_NONSEQ);
    tick();
    a_hresp_s = 4'b1000;
    drive(32'h0000_0000, HT_IDLE);
    sample();
    chk("s3_hresp",  64'(a_hresp),  64'h1);
    chk("s3_hrdata", 64'(a_hrdata), 64'hCAFE_0003);
    tick();
    a_hresp_s = 4'h0;

    // unmapped NONSEQ on the three-slave map, ERR2 overlapping a mapped NONSEQ
    do_reset();
    drive(32'h3000_0000, HT_NONSEQ);
    sample();
    chk("um_hsel",   64'(b_hsel),   64'h0);
    chk("um_ap_rdy", 64'(b_hready), 64'h1);
    chk("um_ap_rsp", 64'(b_hresp),  64'h0);
    tick();
    drive(32'h1000_0000, HT_NONSEQ);
    sample();
    chk("um_err1_rdy",  64'(b_hready), 64'h0);
    chk("um_err1_rsp",  64'(b_hresp),  64'h1);
    chk("um_err1_data", 64'(b_hrdata), 64'h0);
    tick();
    sample();
    chk("um_err2_rdy", 64'(b_hready), 64'h1);
    chk("um_err2_rsp", 64'(b_hresp),  64'h1);
    tick();
    drive(32'h0000_0000, HT_IDLE);
    sample();
    chk("um_next_rdy",  64'(b_hready), 64'h1);
    chk("um_next_rsp",  64'(b_hresp),  64'h0);
    chk("um_next_data", 64'(b_hrdata), 64'hBEEF_0001);

    // two back-to-back unmapped NONSEQs, then an unmapped IDLE
    tick();
    do_reset();
    drive(32'h3000_0000, HT_NONSEQ);
    tick();
    drive(32'h3000_0010, HT_NONSEQ);
    sample();
    chk("bb_err1a_rdy", 64'(b_hready), 64'h0);
    chk("bb_err1a_rsp", 64'(b_hresp),  64'h1);
    tick();
    sample();
    chk("bb_err2a_rdy", 64'(b_hready), 64'h1);
    chk("bb_err2a_rsp", 64'(b_hresp),  64'h1);
    tick();
    drive(32'h3000_0020, HT_IDLE);
    sample();
    chk("bb_err1b_rdy", 64'(b_hready), 64'h0);
    chk("bb_err1b_rsp", 64'(b_hresp),  64'h1);
    tick();
    sample();
    chk("bb_err2b_rdy", 64'(b_hready), 64'h1);
    chk("bb_err2b_rsp", 64'(b_hresp),  64'h1);
    tick();
    drive(32'h0000_0000, HT_IDLE);
    sample();
    chk("bb_idle_rdy",  64'(b_hready), 64'h1);
    chk("bb_idle_rsp",  64'(b_hresp),  64'h0);
    chk("bb_idle_data", 64'(b_hrdata), 64'h0);
    tick();
    sample();
    chk("bb_s0_data", 64'(b_hrdata), 64'hBEEF_0000);

    // overlapping map, then reset asserted in the middle of ERR1
    tick();
    do_reset();
    drive(32'h2000_0000, HT_NONSEQ);
    sample();
    chk("ov_hsel", 64'(c_hsel), 64'h1);
    tick();
    drive(32'h4000_0000, HT_NONSEQ);
    sample();
    chk("ov_s0_data", 64'(c_hrdata), 64'hD00D_0000);
    chk("ov_um_hsel", 64'(c_hsel),   64'h0);
    tick();
    sample();
    chk("ov_err1_rdy", 64'(c_hready), 64'h0);
    chk("ov_err1_rsp", 64'(c_hresp),  64'h1);
    #1 hresetn = 1'b0;
    #1;
    chk("ov_rst_rdy",  64'(c_hready), 64'h1);
    chk("ov_rst_rsp",  64'(c_hresp),  64'h0);
    chk("ov_rst_hsel", 64'(c_hsel),   64'h0);
    chk("ov_rst_data", 64'(c_hrdata), 64'h0);
    tick();
    drive(32'h0000_0000, HT_IDLE);
    hresetn = 1'b1;
    tick();

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
